// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, bias and exponent limits,
// the canonical quiet NaN, rounding-mode encoding and the divider FSM states.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int FRC_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int Q_BITS   = 26;   // 1 integer + 23 fraction + guard + round
    localparam int CNT_W    = 5;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rmode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/fp_round32.sv
// fp_round32: rounds a normalised 24-bit significand (hidden bit at [23]) with
// guard/round/sticky bits, then applies the binary32 exponent range checks.
// Ports:
//   sign, mant[23:0], guard, rnd, sticky : value to round
//   exp_in (signed 10-bit biased exponent), r_mode[2:0]
//   result[31:0] : packed binary32 result
//   ovrf         : exponent overflowed (result per rounding mode)
//   udrf         : exponent underflowed (result flushed to signed zero)
module fp_round32
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic [23:0]       mant,
    input  logic              guard,
    input  logic              rnd,
    input  logic              sticky,
    input  logic signed [9:0] exp_in,
    input  logic [2:0]        r_mode,
    output logic [31:0]       result,
    output logic              ovrf,
    output logic              udrf
);

    logic              inexact;
    logic              round_up;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [22:0]       frc;
    logic [31:0]       inf_val;
    logic [31:0]       max_val;

    always_comb begin
        inexact = guard | rnd | sticky;
        case (r_mode)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & inexact;
            RM_RUP:  round_up = ~sign & inexact;
            RM_RMM:  round_up = guard;
            default: round_up = guard & (rnd | sticky | mant[0]);  // RNE and reserved codes
        endcase

        mant_r = {1'b0, mant} + {24'b0, round_up};
        // Carry-out means the significand rolled over to 2.0: renormalise.
        if (mant_r[24]) begin
            exp_r = exp_in + 10'sd1;
            frc   = mant_r[23:1];
        end else begin
            exp_r = exp_in;
            frc   = mant_r[22:0];
        end

        inf_val = {sign, 8'hFF, 23'h000000};
        max_val = {sign, 8'hFE, 23'h7FFFFF};

        result = {sign, exp_r[7:0], frc};
        ovrf   = 1'b0;
        udrf   = 1'b0;
        if (exp_r >= 10'(EXP_MAX)) begin
            ovrf = 1'b1;
            case (r_mode)
                RM_RTZ:  result = max_val;
                RM_RDN:  result = sign ? inf_val : max_val;
                RM_RUP:  result = sign ? max_val : inf_val;
                default: result = inf_val;
            endcase
        end else if (exp_r <= 10'sd0) begin
            result = {sign, 31'b0};
            udrf   = 1'b1;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative binary32 divider Z = X / Y, radix-2 restoring,
// one quotient bit per cycle. Subnormal operands are treated as zero.
// Handshake: an operand pair is taken on an edge where in_valid && in_ready;
// a result is handed over on an edge where out_valid && out_ready. out_valid
// and the result/flags stay stable until accepted, and no new operands are
// taken until the result has been consumed.
// Ports:
//   clk, rst (synchronous, active high)
//   in_valid/in_ready, fp_X (dividend), fp_Y (divisor), r_mode
//   out_valid/out_ready, fp_Z (quotient), ovrf, udrf, dz, nv
module fp_div_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        dz,
    output logic        nv
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [25:0]       r_q, r_d;       // partial remainder
    logic [23:0]       my_q, my_d;     // divisor significand
    logic [25:0]       quo_q, quo_d;   // quotient bits, MSB first
    logic signed [9:0] ez_q, ez_d;
    logic              sz_q, sz_d;
    logic [2:0]        rmode_q, rmode_d;
    logic [31:0]       z_q, z_d;
    logic              ovrf_q, ovrf_d;
    logic              udrf_q, udrf_d;
    logic              dz_q, dz_d;
    logic              nv_q, nv_d;

    // Operand classification; exponent 0 means zero (subnormals flushed).
    logic [7:0]        ex, ey;
    logic [22:0]       fx, fy;
    logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic [23:0]       mx, my;
    logic signed [9:0] ez_base;
    logic              sz_in;

    assign ex      = fp_X[30:23];
    assign ey      = fp_Y[30:23];
    assign fx      = fp_X[22:0];
    assign fy      = fp_Y[22:0];
    assign x_zero  = (ex == 8'd0);
    assign y_zero  = (ey == 8'd0);
    assign x_inf   = (ex == 8'hFF) && (fx == 23'd0);
    assign y_inf   = (ey == 8'hFF) && (fy == 23'd0);
    assign x_nan   = (ex == 8'hFF) && (fx != 23'd0);
    assign y_nan   = (ey == 8'hFF) && (fy != 23'd0);
    assign mx      = {1'b1, fx};
    assign my      = {1'b1, fy};
    assign sz_in   = fp_X[31] ^ fp_Y[31];
    assign ez_base = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'(EXP_BIAS);

    // One restoring step: the remainder is compared before doubling, so the
    // first step produces the integer quotient bit from mX itself.
    logic        q_bit;
    logic [25:0] r_sub;

    assign q_bit = (r_q >= {2'b00, my_q});
    assign r_sub = q_bit ? (r_q - {2'b00, my_q}) : r_q;

    logic [31:0] rnd_result;
    logic        rnd_ovrf, rnd_udrf;

    fp_round32 u_round (
        .sign   (sz_q),
        .mant   (quo_q[25:2]),
        .guard  (quo_q[1]),
        .rnd    (quo_q[0]),
        .sticky (|r_q),
        .exp_in (ez_q),
        .r_mode (rmode_q),
        .result (rnd_result),
        .ovrf   (rnd_ovrf),
        .udrf   (rnd_udrf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        my_d    = my_q;
        quo_d   = quo_q;
        ez_d    = ez_q;
        sz_d    = sz_q;
        rmode_d = rmode_q;
        z_d     = z_q;
        ovrf_d  = ovrf_q;
        udrf_d  = udrf_q;
        dz_d    = dz_q;
        nv_d    = nv_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sz_d    = sz_in;
                    rmode_d = r_mode;
                    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
                        z_d     = QNAN;
                        nv_d    = 1'b1;
                        state_d = DONE;
                    end else if (x_inf) begin
                        z_d     = {sz_in, 8'hFF, 23'd0};
                        state_d = DONE;
                    end else if (y_zero) begin
                        z_d     = {sz_in, 8'hFF, 23'd0};
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (x_zero || y_inf) begin
                        z_d     = {sz_in, 31'd0};
                        state_d = DONE;
                    end else begin
                        my_d    = my;
                        cnt_d   = '0;
                        quo_d   = '0;
                        state_d = ITER;
                        // Pre-scale so the quotient lands in [1,2).
                        if (mx < my) begin
                            r_d  = {1'b0, mx, 1'b0};
                            ez_d = ez_base - 10'sd1;
                        end else begin
                            r_d  = {2'b00, mx};
                            ez_d = ez_base;
                        end
                    end
                end
            end
            ITER: begin
                r_d   = r_sub << 1;
                quo_d = {quo_q[24:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(Q_BITS - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                z_d     = rnd_result;
                ovrf_d  = rnd_ovrf;
                udrf_d  = rnd_udrf;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ovrf_d  = 1'b0;
                    udrf_d  = 1'b0;
                    dz_d    = 1'b0;
                    nv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            my_q    <= '0;
            quo_q   <= '0;
            ez_q    <= '0;
            sz_q    <= 1'b0;
            rmode_q <= '0;
            z_q     <= '0;
            ovrf_q  <= 1'b0;
            udrf_q  <= 1'b0;
            dz_q    <= 1'b0;
            nv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            my_q    <= my_d;
            quo_q   <= quo_d;
            ez_q    <= ez_d;
            sz_q    <= sz_d;
            rmode_q <= rmode_d;
            z_q     <= z_d;
            ovrf_q  <= ovrf_d;
            udrf_q  <= udrf_d;
            dz_q    <= dz_d;
            nv_q    <= nv_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign fp_Z      = z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;
    assign dz        = dz_q;
    assign nv        = nv_q;

endmodule
